// File: rtl/mipspipe_mem_arbiter.sv
// Arbiter/sequencer sharing one single-port memory between the IF and MEM pipeline stages.
// Define ARB_RR_EN to alternate tie grants; default is fixed data-over-instruction priority.
module mipspipe_mem_arbiter #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant_d,
    output logic              misalign
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              misalign_q, misalign_d;

    logic              grant;
    logic              win_dm;
    logic [31:0]       win_addr;
    logic              last_cycle;

`ifdef ARB_RR_EN
    logic last_dm_q;

    // On a tie, serve whichever port did not get the most recent completed access.
    assign win_dm = (if_req && dm_req) ? ~last_dm_q : dm_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_dm_q <= 1'b0;
        end else if (state_q == StDone) begin
            last_dm_q <= sel_q;
        end
    end
`else
    assign win_dm = dm_req;
`endif

    assign grant      = (state_q == StIdle) && (if_req || dm_req);
    assign win_addr   = win_dm ? dm_addr : if_addr;
    assign last_cycle = (state_q == StBusy) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d    = StBusy;
                    cnt_d      = 4'(WAIT_CYCLES);
                    misalign_d = (win_addr[1:0] != 2'b00);
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            if (grant) begin
                sel_q   <= win_dm;
                addr_q  <= win_addr[ADDR_W+1:2];
                we_q    <= win_dm && dm_we;
                wdata_q <= win_dm ? dm_wdata : 32'd0;
            end
            if (last_cycle && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign mem_en    = (state_q == StBusy);
    assign mem_we    = last_cycle && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant_d   = sel_q;
    assign misalign  = misalign_q;
    assign if_ready  = (state_q == StDone) && !sel_q;
    assign dm_ready  = (state_q == StDone) && sel_q;
    assign if_rdata  = if_ready ? rdata_q : 32'd0;
    assign dm_rdata  = dm_ready ? rdata_q : 32'd0;

    // Address bits above the memory size are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], dm_addr[31:ADDR_W+2]};

endmodule

// File: doc/mipspipe_mem_arbiter.md
# mipspipe_mem_arbiter

Arbiter and sequencer for one single-port unified memory shared by the pipeline's instruction-fetch (IF) and data-memory (MEM) stages. It accepts held-level requests from both stages and grants one at a time. It drives a multi-cycle memory access with a wait-state counter, then returns read data with a one-cycle ready pulse. A stage whose request is not yet served sees ready low and freezes itself.

## Interface
- `ADDR_W`, default 10: word-address width of the memory (1024 words).
- `WAIT_CYCLES`, default 1: extra memory wait states per access (0..15).
- `clock` in, 1: single clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `if_req` in, 1: instruction fetch request, held until `if_ready`.
- `if_addr` in, 32: byte address (the PC).
- `if_rdata` out, 32: fetched instruction, valid while `if_ready`.
- `if_ready` out, 1: one-cycle completion pulse.
- `dm_req` in, 1: data request, held until `dm_ready`.
- `dm_we` in, 1: 1 = store (SW), 0 = load (LW).
- `dm_addr` in, 32: byte address (the ALU result).
- `dm_wdata` in, 32: store data.
- `dm_rdata` out, 32: load data, valid while `dm_ready`.
- `dm_ready` out, 1: one-cycle completion pulse.
- `mem_en` out, 1: memory access active.
- `mem_we` out, 1: memory write strobe.
- `mem_addr` out, ADDR_W: word address, equal to the granted byte address bits [ADDR_W+1:2].
- `mem_wdata` out, 32: write data.
- `mem_rdata` in, 32: memory read data, valid from the second `mem_en` cycle.
- `busy` out, 1: state is not IDLE.
- `grant_d` out, 1: 1 = current/last grant is the data port.
- `misalign` out, 1: one-cycle pulse when the granted address has bits [1:0] != 0.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**:
  - Samples `if_req`/`dm_req`.
  - With no request, it stays in IDLE.
  - With a request, it latches the winner's port select, address, `dm_we` and `dm_wdata` into internal registers, loads cnt = WAIT_CYCLES, and moves to BUSY.
  - `misalign` pulses in the cycle after the grant edge when latched address bits [1:0] != 0. The access still proceeds word-aligned.
- **BUSY**:
  - `mem_en` = 1; `mem_addr` and `mem_wdata` come from the latched registers and stay stable for the whole access.
  - When cnt != 0, cnt decrements.
  - When cnt == 0:
    - `mem_we` is asserted in this cycle only, and only for a store.
    - On a load or fetch, `mem_rdata` is captured into the return register.
    - Next state is DONE.
- **DONE**:
  - Asserts exactly one of `if_ready`/`dm_ready` per `grant_d`.
  - Drives `if_rdata`/`dm_rdata` from the return register; a store returns the last captured value, which is don't-care.
  - Requests are ignored. Next state is IDLE.
  - The requester deasserts its request, or presents a new one, in the cycle after ready.
- **Tie rule** (both requests in IDLE): `dm_req` wins. The MEM instruction is older, so the whole pipeline stalls on MEM anyway.
- The outputs for the port not granted stay 0 in every state.

## Timing
- **Reset values**: state = IDLE, cnt = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `if_ready` = 0, `dm_ready` = 0, `if_rdata` = 0, `dm_rdata` = 0, `busy` = 0, `grant_d` = 0, `misalign` = 0.
- **Latency**:
  - A request seen in IDLE in cycle 0 gives BUSY in cycles 1..WAIT_CYCLES+1 and ready in cycle WAIT_CYCLES+2.
  - IDLE follows in cycle WAIT_CYCLES+3.
  - Throughput is one access per WAIT_CYCLES+3 cycles.
- **Reset during BUSY or DONE**:
  - Reset forces IDLE on the next edge and aborts the access.
  - A store aborted before its cnt == 0 cycle never writes memory.
  - No ready pulse is emitted for the aborted access.
- **Request dropped mid-access**: not allowed. Requests are held; the arbiter completes from latched values regardless.
- **Back-to-back from the same port**: allowed, with one IDLE cycle between accesses.

## Configuration
- **`ARB_RR_EN` defined**:
  - A tie in IDLE is granted to the port not served by the most recent completed grant.
  - The last-served flag is set in DONE; reset sets it to "instruction", so the first tie goes to data.
  - A non-tie request is granted immediately regardless of the flag.
- **`ARB_RR_EN` undefined**: fixed priority, data over instruction.

## Test plan
- **Fetch**: WAIT_CYCLES = 1, memory word 3 = 0x8c0b0010, `if_req` = 1, `if_addr` = 12 at cycle 0 -> `mem_en` high in cycles 1–2 with `mem_addr` = 3; `if_ready` = 1 and `if_rdata` = 0x8c0b0010 in cycle 3; `busy` = 0 in cycle 4.
- **Tie**: both requests at cycle 0, `dm_addr` = 8 (load, word 2 = 0x00000000), `if_addr` = 0 -> `dm_ready` in cycle 3; the fetch is granted in cycle 4 and `if_ready` arrives in cycle 7. Without `ARB_RR_EN`, a second tie also goes to data first.
- **Store then load**: store 0xdeadbeef to byte 36, then load byte 36 -> `mem_we` is high for exactly 1 cycle (cycle 2); the load returns 0xdeadbeef.
- **Reset mid-store**: WAIT_CYCLES = 3, store 0x12345678 to byte 20, `reset` pulsed in cycle 2 -> no `mem_we` pulse, word 5 stays 0xffffffff, no `dm_ready`, all outputs at reset values.
- **Misaligned**: `dm_addr` = 0x0000000e -> `misalign` pulses in cycle 1; `mem_addr` = 3.
- **ARB_RR_EN**: four consecutive ties -> grant order data, instr, data, instr.
